// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with one-entry IF/ID register
// One outstanding imem transaction at a time; redirects drain any in-flight fetch.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic [2:0]  id_imm_op,
  output logic        id_illegal
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_addr;
  logic [31:0] redirect_target;
  logic [31:0] pc_next;
  logic [2:0]  dec_imm_op;
  logic        dec_illegal;
  logic        unused_redirect_lsbs;

  assign redirect_target      = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign pc_next              = pc + 32'd4;
  assign imem_req             = !rst && (state == FETCH || state == DRAIN);
  assign imem_addr            = req_addr;

  // Immediate-format pre-decode of the returning word, latched with id_inst.
  always_comb begin
    dec_imm_op  = 3'b000;
    dec_illegal = 1'b0;
    case (imem_rdata[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0110011: begin
        dec_imm_op = 3'b000;
      end
      7'b0100011:             dec_imm_op = 3'b001;
      7'b1100011:             dec_imm_op = 3'b010;
      7'b0110111, 7'b0010111: dec_imm_op = 3'b011;
      7'b1101111:             dec_imm_op = 3'b100;
      default:                dec_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      req_addr   <= RESET_PC;
      id_valid   <= 1'b0;
      id_inst    <= 32'h0000_0013;
      id_pc      <= 32'h0000_0000;
      id_pc4     <= 32'h0000_0004;
      id_imm_op  <= 3'b000;
      id_illegal <= 1'b0;
    end else if (redirect_valid) begin
      // A killed request that has not been acked must still be drained.
      pc <= redirect_target;
      case (state)
        FETCH: begin
          if (imem_ack) req_addr <= redirect_target;
          else          state    <= DRAIN;
        end
        HOLD: begin
          id_valid <= 1'b0;
          req_addr <= redirect_target;
          state    <= FETCH;
        end
        DRAIN: begin
          if (imem_ack) begin
            req_addr <= redirect_target;
            state    <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            id_valid   <= 1'b1;
            id_inst    <= imem_rdata;
            id_pc      <= pc;
            id_pc4     <= pc_next;
            id_imm_op  <= dec_imm_op;
            id_illegal <= dec_illegal;
            pc         <= pc_next;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (id_ready) begin
            id_valid <= 1'b0;
            req_addr <= pc;
            state    <= FETCH;
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            req_addr <= pc;
            state    <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
// Program-order model plus directed scenarios with literal expectations.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ack, id_valid, id_illegal;
  logic [31:0] imem_addr, imem_rdata, id_inst, id_pc, id_pc4;
  logic [2:0]  id_imm_op;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_ready = 1'b0;

  logic        imem_req2, id_valid2, id_illegal2;
  logic [31:0] imem_addr2, imem_rdata2, id_inst2, id_pc2, id_pc4_2;
  logic [2:0]  id_imm_op2;

  int n_checks = 0;
  int n_fail = 0;
  int lat = 0;
  int age = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_ready(id_ready),
    .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc), .id_pc4(id_pc4),
    .id_imm_op(id_imm_op), .id_illegal(id_illegal)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_req2), .imem_rdata(imem_rdata2),
    .redirect_valid(1'b0), .redirect_pc(32'h0), .id_ready(1'b1),
    .id_valid(id_valid2), .id_inst(id_inst2), .id_pc(id_pc2), .id_pc4(id_pc4_2),
    .id_imm_op(id_imm_op2), .id_illegal(id_illegal2)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h00: return 32'h0050_0093;
      32'h04: return 32'h0011_2023;
      32'h08: return 32'h0000_0463;
      32'h0C: return 32'h0000_12B7;
      32'h10: return 32'h0080_006F;
      32'h14: return 32'h0000_0033;
      32'h18: return 32'h0000_007F;
      default: return {a[13:2], 5'd0, 3'b000, 5'd1, 7'b0010011};
    endcase
  endfunction

  // {illegal, imm_op} from the opcode table
  function automatic logic [3:0] exp_decode(input logic [31:0] w);
    case (w[6:0])
      7'h03, 7'h13, 7'h67, 7'h73, 7'h33: return 4'b0000;
      7'h23:        return 4'b0001;
      7'h63:        return 4'b0010;
      7'h37, 7'h17: return 4'b0011;
      7'h6F:        return 4'b0100;
      default:      return 4'b1000;
    endcase
  endfunction

  assign imem_ack    = imem_req && (age == lat);
  assign imem_rdata  = mem_word(imem_addr);
  assign imem_rdata2 = mem_word(imem_addr2);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  logic [31:0] exp_pc = 32'h0;
  logic        hold_chk = 1'b0, pend_chk = 1'b0, redir_chk = 1'b0;
  logic [31:0] snap_inst, snap_pc, snap_pc4, snap_addr;
  logic [2:0]  snap_imm;
  logic        snap_ill;
  logic [31:0] acked[$];
  logic [31:0] cons_pc[$];
  logic [31:0] cons_inst[$];
  logic [31:0] cons_pc4[$];
  logic [2:0]  cons_imm[$];
  logic        cons_ill[$];

  // Memory latency counter and the program-order model, both on pre-edge values.
  always @(posedge clk) begin
    age <= (rst || !imem_req || imem_ack) ? 0 : age + 1;
    hold_chk  = !rst && !redirect_valid && id_valid && !id_ready;
    pend_chk  = !rst && imem_req && !imem_ack;
    redir_chk = !rst && redirect_valid;
    snap_inst = id_inst; snap_pc = id_pc; snap_pc4 = id_pc4;
    snap_imm  = id_imm_op; snap_ill = id_illegal; snap_addr = imem_addr;
    if (!rst && imem_req && imem_ack) acked.push_back(imem_addr);
    if (rst) exp_pc = 32'h0;
    else if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
    else if (id_valid && id_ready) begin
      cons_pc.push_back(id_pc); cons_inst.push_back(id_inst); cons_pc4.push_back(id_pc4);
      cons_imm.push_back(id_imm_op); cons_ill.push_back(id_illegal);
      exp_pc = exp_pc + 32'd4;
    end
  end

  always @(negedge clk) begin
    logic [31:0] w;
    logic [3:0]  d;
    if (rst) begin
      check("rst_req", imem_req, 0);       check("rst_addr", imem_addr, 32'h0);
      check("rst_valid", id_valid, 0);     check("rst_inst", id_inst, 32'h13);
      check("rst_pc", id_pc, 0);           check("rst_pc4", id_pc4, 4);
      check("rst_imm", id_imm_op, 0);      check("rst_ill", id_illegal, 0);
      check("rst_req2", imem_req2, 0);     check("rst_addr2", imem_addr2, 32'hFFFF_FFFC);
    end else begin
      if (id_valid) begin
        w = mem_word(exp_pc);
        d = exp_decode(w);
        check("model_pc", id_pc, exp_pc);         check("model_inst", id_inst, w);
        check("model_pc4", id_pc4, exp_pc + 4);   check("model_imm", id_imm_op, d[2:0]);
        check("model_ill", id_illegal, d[3]);
      end
      if (hold_chk) begin
        check("hold_valid", id_valid, 1);   check("hold_inst", id_inst, snap_inst);
        check("hold_pc", id_pc, snap_pc);   check("hold_pc4", id_pc4, snap_pc4);
        check("hold_imm", id_imm_op, snap_imm); check("hold_ill", id_illegal, snap_ill);
      end
      if (redir_chk) check("redirect_kill", id_valid, 0);
      if (pend_chk) begin
        check("pend_req", imem_req, 1);
        check("pend_addr", imem_addr, snap_addr);
      end
    end
  end

  task automatic start_test(input int latency, input logic ready);
    @(negedge clk); #1;
    rst = 1'b1; redirect_valid = 1'b0; id_ready = ready;
    repeat (2) @(negedge clk);
    lat = latency;
    acked.delete(); cons_pc.delete(); cons_inst.delete(); cons_pc4.delete();
    cons_imm.delete(); cons_ill.delete();
    #1 rst = 1'b0;
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!id_valid && n < 50);
    check(name, id_valid, 1);
  endtask

  logic [2:0] sw_imm [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd0};
  logic       sw_ill [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    int n;
    // zero-wait memory, streaming consumer; also the wrapping RESET_PC instance
    start_test(0, 1'b1);
    @(negedge clk);
    check("t1_first_valid", id_valid, 1);  check("t1_first_pc", id_pc, 0);
    check("t1_first_inst", id_inst, 32'h0050_0093);
    check("wrap_first_pc", id_pc2, 32'hFFFF_FFFC); check("wrap_first_pc4", id_pc4_2, 0);
    check("wrap_hold_req", imem_req2, 0);
    @(negedge clk);
    check("wrap_second_req", imem_req2, 1); check("wrap_second_addr", imem_addr2, 0);
    check("t1_second_addr", imem_addr, 4);
    repeat (6) @(negedge clk);
    check("t1_acked_n", acked.size() >= 3, 1);
    check("t1_addr0", acked[0], 0); check("t1_addr1", acked[1], 4); check("t1_addr2", acked[2], 8);
    check("t1_cons_n", cons_pc.size() >= 3, 1);
    check("t1_cons_pc1", cons_pc[1], 4); check("t1_cons_pc2", cons_pc[2], 8);
    check("t1_cons_inst", cons_inst[0], 32'h0050_0093); check("t1_cons_pc4", cons_pc4[0], 4);
    check("t1_cons_imm", cons_imm[0], 0); check("t1_cons_ill", cons_ill[0], 0);

    // latency 3, consumer stalls for 5 cycles
    start_test(3, 1'b0);
    wait_valid("t2_valid_timeout", n);
    check("t2_latency", n, 4);
    repeat (5) begin
      @(negedge clk);
      check("t2_stall_valid", id_valid, 1); check("t2_stall_req", imem_req, 0);
      check("t2_stall_pc", id_pc, 0);
    end
    #1 id_ready = 1'b1;
    @(negedge clk); #1 id_ready = 1'b0;
    check("t2_release_valid", id_valid, 0); check("t2_next_addr", imem_addr, 4);
    check("t2_cons_n", cons_pc.size(), 1); check("t2_acked_n", acked.size(), 1);

    // opcode sweep
    start_test(1, 1'b1);
    n = 0;
    while (cons_pc.size() < 7 && n < 100) begin @(negedge clk); n++; end
    check("t3_cons_n", cons_pc.size() >= 7, 1);
    for (int i = 0; i < 7; i++) begin
      check("t3_pc", cons_pc[i], 4 * i);
      check("t3_imm", cons_imm[i], sw_imm[i]);
      check("t3_ill", cons_ill[i], sw_ill[i]);
    end

    // redirect one cycle into an outstanding fetch of 0x8
    start_test(3, 1'b1);
    n = 0;
    do begin @(negedge clk); n++; end while (!(imem_req && imem_addr == 32'h8) && n < 100);
    check("t4_req8_seen", imem_addr, 32'h8);
    @(negedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(negedge clk); #1 redirect_valid = 1'b0;
    check("t4_drain_addr", imem_addr, 32'h8); check("t4_drain_valid", id_valid, 0);
    @(negedge clk);
    check("t4_drain_addr2", imem_addr, 32'h8);
    @(negedge clk);
    check("t4_new_addr", imem_addr, 32'h100); check("t4_new_valid", id_valid, 0);
    repeat (12) @(negedge clk);
    check("t4_acked_n", acked.size() >= 4, 1);
    check("t4_acked8", acked[2], 32'h8); check("t4_acked100", acked[3], 32'h100);
    check("t4_cons_n", cons_pc.size() >= 3, 1); check("t4_cons_pc", cons_pc[2], 32'h100);

    // redirect while holding with consumer stalled
    start_test(0, 1'b0);
    wait_valid("t5_valid_timeout", n);
    check("t5_latency", n, 1);
    #1 redirect_valid = 1'b1; redirect_pc = 32'h203;
    @(negedge clk);
    check("t5_kill_valid", id_valid, 0); check("t5_req", imem_req, 1);
    check("t5_addr", imem_addr, 32'h200);
    #1 redirect_valid = 1'b0; id_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("t5_cons_n", cons_pc.size() >= 1, 1);
    check("t5_cons_pc", cons_pc[0], 32'h200); check("t5_cons_pc4", cons_pc4[0], 32'h204);

    // redirect coinciding with the ack of the first fetch
    start_test(0, 1'b1);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    check("t6_valid", id_valid, 0); check("t6_addr", imem_addr, 32'h40);
    #1 redirect_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_acked_n", acked.size() >= 2, 1);
    check("t6_acked0", acked[0], 0); check("t6_acked1", acked[1], 32'h40);
    check("t6_cons_pc", cons_pc[0], 32'h40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
